// File: rtl/rst_seq_ctrl_pkg.sv
// rst_seq_pkg: shared state encoding, default parameters and index-width helper for the reset sequencer
package rst_seq_pkg;
  typedef enum logic [2:0] {ASSERT, WAIT_ACK, GAP, DONE, ERR} state_t;
  localparam int NUM_STAGES_D = 3;
  localparam int HOLD_CYC_D = 4;
  localparam int STAGE_DLY_D = 16;
  localparam int ACK_TIMEOUT_D = 255;
  localparam int CNT_W_D = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: request/ack inputs and staged reset/status outputs of the reset sequencer
interface rst_seq_ctrl_if import rst_seq_pkg::*; #(
  parameter int NUM_STAGES = NUM_STAGES_D,
  parameter int IW = idx_w(NUM_STAGES)
) ();
  logic SW_RST_REQ;
  logic [NUM_STAGES-1:0] STAGE_ACK;
  logic [NUM_STAGES-1:0] RST_OUT;
  logic SEQ_BUSY;
  logic SEQ_DONE;
  logic SEQ_ERR;
  logic [IW-1:0] ERR_STAGE;
  modport master(input SW_RST_REQ, STAGE_ACK, output RST_OUT, SEQ_BUSY, SEQ_DONE, SEQ_ERR, ERR_STAGE);
  modport slave(output SW_RST_REQ, STAGE_ACK, input RST_OUT, SEQ_BUSY, SEQ_DONE, SEQ_ERR, ERR_STAGE);
endinterface

// File: rtl/rst_seq_ctrl_cnt.sv
// rst_seq_cnt: saturating up-counter with clear/enable and terminal-count compare
module rst_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  assign hit = cnt == term;
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases downstream resets one stage at a time, gated by per-stage ACK and a settle gap
module rst_seq_ctrl import rst_seq_pkg::*; #(
  parameter int NUM_STAGES = NUM_STAGES_D,
  parameter int HOLD_CYC = HOLD_CYC_D,
  parameter int STAGE_DLY = STAGE_DLY_D,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_D,
  parameter int CNT_W = CNT_W_D
) (
  input logic CLK,
  input logic RST,
  rst_seq_ctrl_if.master bus
);
  localparam int IW = idx_w(NUM_STAGES);
  localparam logic [IW-1:0] LAST = IW'(NUM_STAGES - 1);
  state_t st, st_n;
  logic [IW-1:0] k, k_n;
  logic [NUM_STAGES-1:0] ro_n;
  logic [CNT_W-1:0] term;
  logic hit, run;
  assign run = st inside {ASSERT, WAIT_ACK, GAP};
  assign term = CNT_W'(st == ASSERT ? HOLD_CYC - 1 : st == GAP ? STAGE_DLY - 1 : ACK_TIMEOUT - 1);
  rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .clr(bus.SW_RST_REQ || st_n != st),
    .en(run),
    .term(term),
    .hit(hit)
  );
  always_comb begin
    st_n = st;
    k_n = k;
    if (bus.SW_RST_REQ) begin
      st_n = ASSERT;
      k_n = '0;
    end else begin
      case (st)
        ASSERT: if (hit) begin
          st_n = WAIT_ACK;
          k_n = '0;
        end
        WAIT_ACK: if (bus.STAGE_ACK[k]) st_n = (k == LAST) ? DONE : GAP;
          else if (hit) st_n = ERR;
        GAP: if (hit) begin
          st_n = WAIT_ACK;
          k_n = k + 1'b1;
        end
        default: ;
      endcase
    end
    // stages up to k are released; ASSERT and ERR hold everything in reset
    for (int i = 0; i < NUM_STAGES; i++)
      ro_n[i] = st_n inside {ASSERT, ERR} || (st_n != DONE && i > int'(k_n));
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st <= ASSERT;
      k <= '0;
      bus.RST_OUT <= '1;
      bus.SEQ_BUSY <= 1'b1;
      bus.SEQ_DONE <= 1'b0;
      bus.SEQ_ERR <= 1'b0;
      bus.ERR_STAGE <= '0;
    end else begin
      st <= st_n;
      k <= k_n;
      bus.RST_OUT <= ro_n;
      bus.SEQ_BUSY <= st_n inside {ASSERT, WAIT_ACK, GAP};
      bus.SEQ_DONE <= st_n == DONE;
      bus.SEQ_ERR <= st_n == ERR;
      bus.ERR_STAGE <= (st_n == ERR) ? k_n : '0;
    end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: randomized episodes with a timeline model feeding an output-change scoreboard
module tb_rst_seq_ctrl;
  localparam int N = 3, HOLD = 4, DLY = 16, TO = 100, IW = 2, BIG = 1 << 30;
  typedef struct packed {logic [N-1:0] ro; logic busy; logic done; logic err; logic [IW-1:0] es;} obs_t;
  typedef struct {int at; obs_t o;} ev_t;
  localparam obs_t RST_V = {{N{1'b1}}, 1'b1, 1'b0, 1'b0, {IW{1'b0}}};
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  rst_seq_ctrl_if #(.NUM_STAGES(N), .IW(IW)) bus ();
  rst_seq_ctrl #(.NUM_STAGES(N), .HOLD_CYC(HOLD), .STAGE_DLY(DLY), .ACK_TIMEOUT(TO), .CNT_W(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );
  ev_t q[$], plan_q[$];
  obs_t last, prev;
  int cyc = 0, compared = 0, mismatched = 0;
  int rl[N], t[N], acc[N];
  bit drp[N];
  int E, I, B, nrel, m;
  bit use_rst;

  function automatic obs_t sample();
    return {bus.RST_OUT, bus.SEQ_BUSY, bus.SEQ_DONE, bus.SEQ_ERR, bus.ERR_STAGE};
  endfunction
  function automatic obs_t stage_v(input int s);
    obs_t o;
    o = RST_V;
    o.ro = N'((1 << N) - (1 << (s + 1)));
    return o;
  endfunction
  function automatic obs_t end_v(input bit err, input int s);
    obs_t o;
    o.ro = err ? {N{1'b1}} : '0;
    o.busy = 1'b0;
    o.done = !err;
    o.err = err;
    o.es = err ? IW'(s) : '0;
    return o;
  endfunction
  task automatic emit(input int at, input obs_t o);
    if (o != last) begin
      q.push_back('{at, o});
      last = o;
    end
  endtask
  task automatic chk(input string nm, input obs_t got, input obs_t exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %h required %h", nm, cyc, got, exp);
    end
  endtask

  // Timeline from the rules: release edges, acceptance edges, DONE or ERR edge
  task automatic plan(input int ep);
    int rel, off, a, r;
    plan_q.delete();
    rel = B + HOLD;
    nrel = 0;
    for (int s = 0; s < N; s++) begin
      t[s] = BIG;
      acc[s] = BIG;
    end
    for (int s = 0; s < N; s++) begin
      rl[s] = rel;
      nrel++;
      plan_q.push_back('{rel, stage_v(s)});
      r = $urandom_range(0, 9);
      off = (r == 0) ? TO + $urandom_range(0, 30) : (r == 1) ? TO - 2 + $urandom_range(0, 1) :
            (r == 2) ? -$urandom_range(1, 8) : $urandom_range(0, 20);
      if (ep == 0) off = -1000;
      if (ep == 1 && s == 1) off = TO;
      t[s] = rel + off;
      drp[s] = 1'($urandom_range(0, 1));
      a = (t[s] > rel) ? t[s] + 1 : rel + 1;
      if (a > rel + TO) begin
        E = rel + TO;
        plan_q.push_back('{E, end_v(1'b1, s)});
        return;
      end
      acc[s] = a;
      if (s == N - 1) begin
        E = a;
        plan_q.push_back('{E, end_v(1'b0, 0)});
      end else rel = a + DLY;
    end
  endtask
  task automatic drive_acks(input int c);
    for (int s = 0; s < N; s++)
      bus.STAGE_ACK[s] = (c > E) ? 1'($urandom_range(0, 1)) : (c >= t[s] && !(drp[s] && c > acc[s]));
  endtask

  always @(posedge CLK) begin : mon
    obs_t cur;
    ev_t e;
    cyc++;
    #1 cur = sample();
    if (cur !== prev) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change at edge %0d: got %h, required unchanged %h", cyc, cur, prev);
      end else begin
        e = q.pop_front();
        if (e.at != cyc || cur !== e.o) begin
          mismatched++;
          $display("FAIL event at edge %0d: got %h, required %h at edge %0d", cyc, cur, e.o, e.at);
        end
      end
      prev = cur;
    end
  end

  initial begin
    bus.SW_RST_REQ = 1'b0;
    bus.STAGE_ACK = '0;
    last = RST_V;
    prev = RST_V;
    E = 0;
    repeat (3) @(negedge CLK);
    chk("reset_state", sample(), RST_V);
    RST = 1'b0;
    B = cyc;
    for (int ep = 0; ep < 30; ep++) begin
      plan(ep);
      m = (ep < 2) ? 0 : (ep == 2) ? 3 : $urandom_range(0, 3);
      if (m <= 1) I = E + $urandom_range(1, 20);
      else if (m == 2) I = $urandom_range(B + 1, E);
      else I = (nrel >= 2) ? rl[$urandom_range(1, nrel - 1)] : E + 1;
      use_rst = (m == 3 || ep == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      foreach (plan_q[j]) if (plan_q[j].at < I) emit(plan_q[j].at, plan_q[j].o);
      forever begin
        drive_acks(cyc);
        if (cyc >= I - 1) break;
        @(negedge CLK);
      end
      emit(I, RST_V);
      if (use_rst) begin
        RST = 1'b1;
        #1 chk("async_reset", sample(), RST_V);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
      end else begin
        bus.SW_RST_REQ = 1'b1;
        @(negedge CLK);
        bus.SW_RST_REQ = 1'b0;
      end
      B = cyc;
    end
    plan(2);
    foreach (plan_q[j]) emit(plan_q[j].at, plan_q[j].o);
    while (cyc < E + 8) begin
      drive_acks(cyc);
      @(negedge CLK);
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_events: got %0d pending, required 0 (next at edge %0d)", q.size(), q[0].at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
